// File: rtl/prbs_pkg.sv
// Shared types and constants for the serial PRBS5 checker.
// The recurrence b[n] = b[n-5] ^ b[n-2] maps onto history taps 4 and 1.
package prbs_pkg;

   typedef enum logic [1:0] {FILL, SEARCH, LOCKED} state_e;

   localparam int PRBS_LEN = 5;
   localparam int TAP_A    = 4;
   localparam int TAP_B    = 1;

   localparam int DEF_SYNC_LEN    = 8;
   localparam int DEF_LOSS_THRESH = 4;
   localparam int DEF_LOSS_WIN    = 32;
   localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// A clear in the same cycle as an increment yields a count of one.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;
   logic [W-1:0] w_base;

   assign w_base = clr ? '0 : r_count;
   assign count  = r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_count <= '0;
      else if (clr || inc)
         r_count <= (inc && (w_base != '1)) ? w_base + W'(1) : w_base;
   end

endmodule

// File: rtl/prbs5_checker.sv
// Self-synchronising PRBS5 checker: fills a 5-bit history, searches for a run of
// correct predictions, then free-runs its own reference and flags mismatches.
module prbs5_checker
   import prbs_pkg::*;
#(
   parameter int SYNC_LEN    = DEF_SYNC_LEN,
   parameter int LOSS_THRESH = DEF_LOSS_THRESH,
   parameter int LOSS_WIN    = DEF_LOSS_WIN,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             clr,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] bit_count
);

   localparam logic [2:0] FILL_LAST = 3'(PRBS_LEN - 1);
   localparam logic [7:0] SYNC_C    = SYNC_LEN[7:0];
   localparam logic [8:0] THRESH_C  = LOSS_THRESH[8:0];
   localparam logic [8:0] WIN_C     = LOSS_WIN[8:0];

   state_e                r_state, w_state_nx;
   logic [PRBS_LEN-1:0]   r_hist, w_hist_nx;
   logic [2:0]            r_fill_cnt, w_fill_nx;
   logic [7:0]            r_match_cnt, w_match_nx;
   logic [8:0]            r_win_bits, w_win_bits_nx;
   logic [8:0]            r_win_err, w_win_err_nx;
   logic                  r_locked, r_err_pulse;

   logic                  w_pred, w_err, w_inc_err, w_inc_bit;
   logic [8:0]            w_win_bits_inc, w_win_err_inc;

   assign w_pred         = r_hist[TAP_A] ^ r_hist[TAP_B];
   assign w_err          = in_bit ^ w_pred;
   assign w_win_bits_inc = r_win_bits + 9'd1;
   assign w_win_err_inc  = r_win_err + {8'd0, w_err};

   always_comb begin
      w_state_nx    = r_state;
      w_hist_nx     = r_hist;
      w_fill_nx     = r_fill_cnt;
      w_match_nx    = r_match_cnt;
      w_win_bits_nx = r_win_bits;
      w_win_err_nx  = r_win_err;
      w_inc_err     = 1'b0;
      w_inc_bit     = 1'b0;
      if (in_valid) begin
         case (r_state)
            FILL: begin
               w_hist_nx = {r_hist[PRBS_LEN-2:0], in_bit};
               if (r_fill_cnt == FILL_LAST) begin
                  w_fill_nx  = 3'd0;
                  w_state_nx = SEARCH;
               end else begin
                  w_fill_nx  = r_fill_cnt + 3'd1;
               end
            end
            SEARCH: begin
               w_hist_nx = {r_hist[PRBS_LEN-2:0], in_bit};
               // An all-zero history predicts zeros forever, so it never counts as a match.
               if (!w_err && (r_hist != '0)) begin
                  if (r_match_cnt + 8'd1 == SYNC_C) begin
                     w_state_nx    = LOCKED;
                     w_match_nx    = 8'd0;
                     w_win_bits_nx = 9'd0;
                     w_win_err_nx  = 9'd0;
                  end else begin
                     w_match_nx    = r_match_cnt + 8'd1;
                  end
               end else begin
                  w_match_nx = 8'd0;
               end
            end
            LOCKED: begin
               // Self-referencing keeps one corrupted input bit to exactly one error.
               w_hist_nx = {r_hist[PRBS_LEN-2:0], w_pred};
               w_inc_bit = 1'b1;
               w_inc_err = w_err;
               if (w_win_err_inc == THRESH_C) begin
                  w_state_nx    = FILL;
                  w_fill_nx     = 3'd0;
                  w_match_nx    = 8'd0;
                  w_win_bits_nx = 9'd0;
                  w_win_err_nx  = 9'd0;
               end else if (w_win_bits_inc == WIN_C) begin
                  w_win_bits_nx = 9'd0;
                  w_win_err_nx  = 9'd0;
               end else begin
                  w_win_bits_nx = w_win_bits_inc;
                  w_win_err_nx  = w_win_err_inc;
               end
            end
            default: w_state_nx = FILL;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= FILL;
         r_hist      <= '0;
         r_fill_cnt  <= 3'd0;
         r_match_cnt <= 8'd0;
         r_win_bits  <= 9'd0;
         r_win_err   <= 9'd0;
         r_locked    <= 1'b0;
         r_err_pulse <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_hist      <= w_hist_nx;
         r_fill_cnt  <= w_fill_nx;
         r_match_cnt <= w_match_nx;
         r_win_bits  <= w_win_bits_nx;
         r_win_err   <= w_win_err_nx;
         r_locked    <= (w_state_nx == LOCKED);
         r_err_pulse <= w_inc_err;
      end
   end

   assign locked    = r_locked;
   assign err_pulse = r_err_pulse;

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (w_inc_err),
      .count (err_count)
   );

   sat_counter #(.W(CNT_W)) u_bit_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (w_inc_bit),
      .count (bit_count)
   );

endmodule

// File: doc/prbs5_checker.md
# prbs5_checker

Serial PRBS5 checker sitting directly downstream of the 5-bit LFSR generator. It consumes the generator's serial output and self-synchronises to the sequence b[n] = b[n-5] ^ b[n-2], which has period 31. Once locked, it runs a free-running reference and flags every mismatching bit. It reports lock status, per-bit error pulses and saturating error/bit counters to the power-management verification logic.

## Interface
- SYNC_LEN, 8: consecutive correct predictions required to declare lock (1..255).
- LOSS_THRESH, 4: errors within one window that force loss of lock (1..LOSS_WIN).
- LOSS_WIN, 32: window length in valid bits (2..256).
- CNT_W, 16: width of err_count and bit_count.
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: in_bit is sampled this cycle.
- in_bit, input, 1: serial PRBS bit from the generator's `out`.
- clr, input, 1: synchronous clear of err_count and bit_count; state is unaffected.
- locked, output, 1: checker is in LOCKED.
- err_pulse, output, 1: one-cycle pulse per mismatching bit while LOCKED.
- err_count, output, CNT_W: saturating count of errors since reset or clr.
- bit_count, output, CNT_W: saturating count of bits checked while LOCKED.

## Operation
- State machine with three states:
  - FILL: shift valid bits into a 5-bit history, hist[0] newest. After 5 valid bits, go to SEARCH.
  - SEARCH: prediction pred = hist[4] ^ hist[1].
    - A valid bit matches if in_bit == pred and hist != 0. A match increments match_cnt; otherwise match_cnt is cleared.
    - hist shifts in in_bit.
    - When match_cnt reaches SYNC_LEN, go to LOCKED and clear the window counters.
  - LOCKED: hist shifts in pred, not in_bit, so one corrupted input bit produces exactly one error.
    - in_bit != pred raises err_pulse and increments err_count and win_err.
    - Every valid bit increments bit_count and win_bits.
- Window rules:
  - If win_err reaches LOSS_THRESH, go to FILL. fill_cnt, match_cnt and the window counters clear; hist is kept but refilled.
  - When win_bits reaches LOSS_WIN without loss, clear win_bits and win_err.
  - If the threshold is hit on the last bit of a window, loss of lock wins.
- Cycles with in_valid = 0 leave all state and counters unchanged, and err_pulse = 0.
- Counters saturate at 2^CNT_W − 1 and never wrap.
- When clr coincides with a counted event, the clear applies first, then the increment, so the counter ends at 1.
- Errors are neither counted nor pulsed in FILL or SEARCH.
- All-zero input never locks, because of the hist != 0 guard.
- Reset values: state = FILL, hist = 0, all internal counters = 0, locked = 0, err_pulse = 0, err_count = 0, bit_count = 0.
- Reset asserted mid-lock returns all of the above asynchronously. Checking resumes with FILL on the first valid bit after deassertion.

## Timing
- All outputs are registered.
- err_pulse, err_count and bit_count update on the clock edge that samples the bit and are visible the following cycle: one cycle of latency.
- locked rises one cycle after the valid bit that completes SYNC_LEN matches. With continuous valid and a correct stream, that is 5 + SYNC_LEN = 13 valid bits after reset.
- locked falls one cycle after the bit that reaches LOSS_THRESH. That bit is still counted and pulsed.
- Throughput: one bit per cycle, with no backpressure.

## Structure
- Package prbs_pkg holds:
  - the state enum {FILL, SEARCH, LOCKED};
  - PRBS_LEN = 5;
  - tap constants TAP_A = 4 and TAP_B = 1;
  - the default parameter values.
- Sub-module sat_counter (parameter W; inputs clr, inc; output count) is instantiated for err_count and bit_count.
- All other logic, including the prediction, history and state machine, lives in prbs5_checker.

## Test plan
- Reset: drive rst = 1 for 3 cycles with random in_bit. Required: locked = 0, err_pulse = 0, err_count = 0, bit_count = 0 throughout.
- Clean lock: generator seeded to 5'b10000, in_valid = 1 continuously. Required: locked = 1 one cycle after the 13th bit; after 200 more bits, err_count = 0 and bit_count = 200.
- Single error: while locked, invert one bit. Required: exactly one err_pulse, err_count = 1, locked stays 1, and no further pulses afterwards.
- Loss of lock:
  - Invert 4 bits within 32 valid bits. Required: locked = 0 one cycle after the 4th, err_count = 4, then relock after 13 clean bits.
  - Invert 3 bits per 32-bit window. Required: lock is never lost.
- All-zero and gaps:
  - in_bit = 0 for 100 bits. Required: never locks.
  - Clean stream with in_valid every other cycle. Required: lock after 13 valid bits, i.e. 26 cycles.
- Clear and saturation:
  - clr asserted in the same cycle as an error. Required: err_count = 1.
  - With CNT_W = 4, inject 20 errors across windows. Required: err_count holds at 15.
  - rst mid-lock. Required: all outputs return to 0 immediately.
